// File: rtl/wbuidlevec_pkg.sv
// Shared debug-bus codeword definitions: width, header codes and output-slot kinds.
package wbuidlevec_pkg;

  localparam int CW_WIDTH   = 36;
  localparam int CW_PAYLOAD = 30;

  localparam logic [5:0] CW_INTERRUPT = 6'h04;
  localparam logic [5:0] CW_BUSBUSY   = 6'h01;
  localparam logic [5:0] CW_IDLE      = 6'h00;

  // What the output register currently holds; decides which accept side effects fire.
  typedef enum logic [1:0] {
    OUT_NONE = 2'd0,
    OUT_BUS  = 2'd1,
    OUT_INT  = 2'd2,
    OUT_KA   = 2'd3
  } out_kind_t;

endpackage

// File: rtl/wbuintvec.sv
// Per-line interrupt tracker: level high fires once, re-arms after release and clear.
// Pending updates one cycle after a line rises; sent_mask snapshot is cleared on accept.
module wbuintvec #(
  parameter int NINT = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NINT-1:0] i_int,
  input  logic            i_load,
  input  logic            i_accept,
  output logic [NINT-1:0] o_pending
);

  logic [NINT-1:0] pending;
  logic [NINT-1:0] armed;
  logic [NINT-1:0] sent_mask;
  logic [NINT-1:0] new_set;

  assign new_set   = i_int & armed;
  assign o_pending = pending;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending   <= '0;
      armed     <= '1;
      sent_mask <= '0;
    end else begin
      // Lines that rise while a vector is in flight survive the clear.
      if (i_accept)
        pending <= (pending & ~sent_mask) | new_set;
      else
        pending <= pending | new_set;
      armed <= ~i_int & (armed | ~pending);
      if (i_load)
        sent_mask <= pending;
    end
  end

endmodule

// File: rtl/wbuidlevec.sv
// Merges bus results, interrupt vectors and idle/bus-busy keep-alives into one codeword stream.
// Latency 1 cycle from i_stb; output register holds stable while i_tx_busy.
module wbuidlevec
  import wbuidlevec_pkg::*;
#(
  parameter int NINT          = 8,
  parameter int IDLEBITS      = 31,
  parameter bit OPT_HEARTBEAT = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_stb,
  input  logic [CW_WIDTH-1:0] i_codword,
  input  logic                i_cyc,
  input  logic                i_busy,
  input  logic [NINT-1:0]     i_int,
  output logic                o_stb,
  output logic [CW_WIDTH-1:0] o_codword,
  output logic                o_busy,
  output logic [NINT-1:0]     o_int_pending,
  input  logic                i_tx_busy
);

  logic                  load_ok;
  logic                  accept;
  logic                  int_accept;
  logic                  ka_accept;
  logic                  int_load;
  logic [NINT-1:0]       pending;
  logic [CW_PAYLOAD-1:0] int_payload;
  logic [IDLEBITS-1:0]   idle_counter;
  logic                  idle_state;
  logic                  idle_expired;
  logic                  ctr_clear;
  out_kind_t             out_kind;
  out_kind_t             kind_nx;
  logic                  stb_nx;
  logic [CW_WIDTH-1:0]   cw_nx;

  assign load_ok      = !o_stb || !i_tx_busy;
  assign accept       = o_stb && !i_tx_busy;
  assign int_accept   = accept && (out_kind == OUT_INT);
  assign ka_accept    = accept && (out_kind == OUT_KA);
  assign int_load     = load_ok && (kind_nx == OUT_INT);
  assign idle_expired = !idle_state && idle_counter[IDLEBITS-1];
  assign o_busy        = o_stb;
  assign o_int_pending = pending;

  wbuintvec #(.NINT(NINT)) u_intvec (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_int     (i_int),
    .i_load    (int_load),
    .i_accept  (int_accept),
    .o_pending (pending)
  );

  always_comb begin
    int_payload = '0;
    int_payload[NINT-1:0] = pending;
  end

  // Generated codewords wait for an empty register, leaving one bubble between them.
  always_comb begin
    stb_nx  = 1'b0;
    cw_nx   = '0;
    kind_nx = OUT_NONE;
    if (i_stb) begin
      stb_nx  = 1'b1;
      cw_nx   = i_codword;
      kind_nx = OUT_BUS;
    end else if ((|pending) && !o_stb) begin
      stb_nx  = 1'b1;
      cw_nx   = {CW_INTERRUPT, int_payload};
      kind_nx = OUT_INT;
    end else if (idle_expired && !o_stb) begin
      stb_nx  = 1'b1;
      cw_nx   = {(i_cyc ? CW_BUSBUSY : CW_IDLE), {CW_PAYLOAD{1'b0}}};
      kind_nx = OUT_KA;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stb     <= 1'b0;
      o_codword <= '0;
      out_kind  <= OUT_NONE;
    end else if (load_ok) begin
      o_stb    <= stb_nx;
      out_kind <= kind_nx;
      if (stb_nx)
        o_codword <= cw_nx;
    end
  end

  // Without heartbeat a keep-alive must not restart the quiet period, so the counter
  // stays saturated and idle_state stays set until real traffic appears.
  assign ctr_clear = i_stb || i_busy ||
                     (o_stb && (OPT_HEARTBEAT || (out_kind != OUT_KA)));

  always_ff @(posedge i_clk) begin
    if (i_reset || ctr_clear)
      idle_counter <= '0;
    else if (!idle_counter[IDLEBITS-1])
      idle_counter <= idle_counter + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      idle_state <= 1'b1;
    else if (ka_accept)
      idle_state <= !OPT_HEARTBEAT;
    else if (!idle_counter[IDLEBITS-1])
      idle_state <= 1'b0;
  end

endmodule
